// File: rtl/output_image_register_pkg.sv
// Shared constants and the watchdog state encoding for the output image register.
package output_image_register_pkg;

  localparam int outputNumber     = 8;
  localparam int outputAddrLen    = 3;
  localparam int wdtCyclesDefault = 1000;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } wdtState_t;

endpackage

// File: rtl/output_image_register_scan_watchdog.sv
// Scan watchdog: counts cycles between scanEnd pulses and trips to FAULT on expiry.
module scan_watchdog
  import output_image_register_pkg::*;
#(
  parameter int WDT_CYCLES = wdtCyclesDefault
) (
  input  logic clk,
  input  logic reset,
  input  logic scanEnd,
  output logic expire,
  output logic wdtFault
);

  localparam int CNT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WDT_CYCLES - 1);

  wdtState_t        state;
  logic [CNT_W-1:0] count;
  logic             atLimit;

  assign atLimit = (count == LAST_COUNT);
  // A scanEnd arriving in the expiry cycle takes priority over the trip.
  assign expire  = (state == RUN) && atLimit && !scanEnd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      count    <= '0;
      wdtFault <= 1'b0;
    end else if (scanEnd) begin
      state    <= RUN;
      count    <= '0;
      wdtFault <= 1'b0;
    end else begin
      // Counter parks at the limit, so it holds there for the whole FAULT period.
      if (!atLimit) begin
        count <= count + CNT_W'(1);
      end
      if (expire) begin
        state    <= FAULT;
        wdtFault <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_image_register.sv
// Shadow output image written bit-by-bit, committed to the pins at end of scan,
// with a scan watchdog forcing the pins to a safe pattern when scans stop.
module output_image_register
  import output_image_register_pkg::*;
#(
  parameter int                 OUT_NUM      = outputNumber,
  parameter int                 OUT_ADDR_LEN = outputAddrLen,
  parameter int                 WDT_CYCLES   = wdtCyclesDefault,
  parameter logic [OUT_NUM-1:0] SAFE_STATE   = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    outputWrite,
  input  logic [OUT_ADDR_LEN-1:0] outputWriteAddr,
  input  logic                    outputWriteData,
  input  logic                    outputRead,
  input  logic [OUT_ADDR_LEN-1:0] outputReadAddr,
  output logic                    outputReadOut,
  input  logic                    scanEnd,
  output logic [OUT_NUM-1:0]      outputs,
  output logic                    outputsUpdated,
  output logic                    wdtFault
);

  localparam int ADDR_SPAN = 1 << OUT_ADDR_LEN;

  logic [OUT_NUM-1:0]   image;
  logic [OUT_NUM-1:0]   imageNext;
  logic [ADDR_SPAN-1:0] readVector;
  logic                 expire;

  // imageNext carries this cycle's write, so commit and readback see it immediately.
  genvar gi;
  generate
    for (gi = 0; gi < OUT_NUM; gi++) begin : g_bit
      assign imageNext[gi] = (outputWrite && (outputWriteAddr == OUT_ADDR_LEN'(gi)))
                             ? outputWriteData : image[gi];
    end

    // Addresses beyond OUT_NUM read back as zero.
    for (gi = 0; gi < ADDR_SPAN; gi++) begin : g_read
      if (gi < OUT_NUM) begin : g_valid
        assign readVector[gi] = imageNext[gi];
      end else begin : g_pad
        assign readVector[gi] = 1'b0;
      end
    end
  endgenerate

  scan_watchdog #(
    .WDT_CYCLES(WDT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .scanEnd (scanEnd),
    .expire  (expire),
    .wdtFault(wdtFault)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      image          <= '0;
      outputs        <= SAFE_STATE;
      outputReadOut  <= 1'b0;
      outputsUpdated <= 1'b0;
    end else begin
      image          <= imageNext;
      outputsUpdated <= scanEnd;
      if (outputRead) begin
        outputReadOut <= readVector[outputReadAddr];
      end
      if (scanEnd) begin
        outputs <= imageNext;
      end else if (expire) begin
        outputs <= SAFE_STATE;
      end
    end
  end

endmodule

// File: tb/tb_output_image_register.sv
// Directed bench for output_image_register: table of single-cycle vectors plus
// hand-written watchdog and asynchronous reset sequences.
module tb_output_image_register;

  logic       clk = 1'b0;
  logic       reset;
  logic       outputWrite;
  logic [2:0] outputWriteAddr;
  logic       outputWriteData;
  logic       outputRead;
  logic [2:0] outputReadAddr;
  logic       scanEnd;

  logic       outputReadOut;
  logic [7:0] outputs;
  logic       outputsUpdated;
  logic       wdtFault;

  logic       narrowReadOut;
  logic [5:0] narrowOutputs;
  logic       narrowUpdated;
  logic       narrowFault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  output_image_register #(
    .OUT_NUM(8), .OUT_ADDR_LEN(3), .WDT_CYCLES(10), .SAFE_STATE(8'h00)
  ) dut (
    .clk(clk), .reset(reset),
    .outputWrite(outputWrite), .outputWriteAddr(outputWriteAddr),
    .outputWriteData(outputWriteData),
    .outputRead(outputRead), .outputReadAddr(outputReadAddr),
    .outputReadOut(outputReadOut),
    .scanEnd(scanEnd), .outputs(outputs),
    .outputsUpdated(outputsUpdated), .wdtFault(wdtFault)
  );

  output_image_register #(
    .OUT_NUM(6), .OUT_ADDR_LEN(3), .WDT_CYCLES(10), .SAFE_STATE(6'h00)
  ) dutNarrow (
    .clk(clk), .reset(reset),
    .outputWrite(outputWrite), .outputWriteAddr(outputWriteAddr),
    .outputWriteData(outputWriteData),
    .outputRead(outputRead), .outputReadAddr(outputReadAddr),
    .outputReadOut(narrowReadOut),
    .scanEnd(scanEnd), .outputs(narrowOutputs),
    .outputsUpdated(narrowUpdated), .wdtFault(narrowFault)
  );

  typedef struct {
    logic       wr;
    logic [2:0] wAddr;
    logic       wData;
    logic       rd;
    logic [2:0] rAddr;
    logic       scan;
    logic [7:0] expOut;
    logic       expRead;
    logic       expUpd;
    logic [5:0] expNarrowOut;
    logic       expNarrowRead;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic wr, input logic [2:0] wa, input logic wd,
                       input logic rd, input logic [2:0] ra, input logic se);
    outputWrite     = wr;
    outputWriteAddr = wa;
    outputWriteData = wd;
    outputRead      = rd;
    outputReadAddr  = ra;
    scanEnd         = se;
    @(posedge clk);
    #1;
    outputWrite = 1'b0;
    outputRead  = 1'b0;
    scanEnd     = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    //            wr  wA    wD  rd  rA    scan  out    rd   upd  nOut   nRd
    vecs[0]  = '{1'b1, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 6'h00, 1'b0};
    vecs[1]  = '{1'b1, 3'd3, 1'b1, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 6'h00, 1'b1};
    vecs[2]  = '{1'b1, 3'd7, 1'b1, 1'b1, 3'd7, 1'b0, 8'h00, 1'b1, 1'b0, 6'h00, 1'b0};
    vecs[3]  = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 8'h89, 1'b1, 1'b1, 6'h09, 1'b1};
    vecs[4]  = '{1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h89, 1'b1, 1'b0, 6'h09, 1'b1};
    vecs[5]  = '{1'b1, 3'd7, 1'b0, 1'b1, 3'd7, 1'b1, 8'h09, 1'b0, 1'b1, 6'h09, 1'b0};
    vecs[6]  = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 8'h09, 1'b0, 1'b0, 6'h09, 1'b0};
    vecs[7]  = '{1'b1, 3'd1, 1'b1, 1'b0, 3'd0, 1'b0, 8'h09, 1'b0, 1'b0, 6'h09, 1'b0};
    vecs[8]  = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 8'h09, 1'b1, 1'b0, 6'h09, 1'b1};
    vecs[9]  = '{1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h0B, 1'b1, 1'b1, 6'h0B, 1'b1};
    vecs[10] = '{1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 1'b1, 8'h0F, 1'b1, 1'b1, 6'h0F, 1'b1};
    vecs[11] = '{1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h0F, 1'b1, 1'b1, 6'h0F, 1'b1};
    vecs[12] = '{1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h0F, 1'b1, 1'b0, 6'h0F, 1'b1};

    reset           = 1'b0;
    outputWrite     = 1'b0;
    outputWriteAddr = 3'd0;
    outputWriteData = 1'b0;
    outputRead      = 1'b0;
    outputReadAddr  = 3'd0;
    scanEnd         = 1'b0;

    #12;
    check("reset_outputs", outputs, 8'h00);
    check("reset_fault", wdtFault, 1'b0);
    check("reset_readout", outputReadOut, 1'b0);
    check("reset_updated", outputsUpdated, 1'b0);
    $display("reset: outputs=%h wdtFault=%b readOut=%b", outputs, wdtFault, outputReadOut);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].wr, vecs[i].wAddr, vecs[i].wData, vecs[i].rd, vecs[i].rAddr, vecs[i].scan);
      $display("vec %0d: wr=%b@%0d=%b rd=%b@%0d scan=%b -> outputs=%h readOut=%b upd=%b narrow=%h/%b",
               i, vecs[i].wr, vecs[i].wAddr, vecs[i].wData, vecs[i].rd, vecs[i].rAddr,
               vecs[i].scan, outputs, outputReadOut, outputsUpdated, narrowOutputs, narrowReadOut);
      check($sformatf("vec%0d_outputs", i), outputs, vecs[i].expOut);
      check($sformatf("vec%0d_readout", i), outputReadOut, vecs[i].expRead);
      check($sformatf("vec%0d_updated", i), outputsUpdated, vecs[i].expUpd);
      check($sformatf("vec%0d_fault", i), wdtFault, 1'b0);
      check($sformatf("vec%0d_narrow_outputs", i), narrowOutputs, vecs[i].expNarrowOut);
      check($sformatf("vec%0d_narrow_readout", i), narrowReadOut, vecs[i].expNarrowRead);
    end

    // Fill the image with ones, committing alongside each write.
    for (int b = 0; b < 8; b++) begin
      cycle(1'b1, 3'(b), 1'b1, 1'b0, 3'd0, 1'b1);
    end
    $display("fill: outputs=%h", outputs);
    check("fill_outputs", outputs, 8'hFF);

    // Watchdog trips 10 edges after the last scanEnd.
    for (int k = 1; k <= 10; k++) begin
      idle();
      $display("wdt idle %0d: outputs=%h wdtFault=%b", k, outputs, wdtFault);
      if (k == 9) begin
        check("wdt_pre_fault", wdtFault, 1'b0);
        check("wdt_pre_outputs", outputs, 8'hFF);
      end
      if (k == 10) begin
        check("wdt_fault", wdtFault, 1'b1);
        check("wdt_safe_outputs", outputs, 8'h00);
      end
    end

    cycle(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    $display("fault write: outputs=%h wdtFault=%b", outputs, wdtFault);
    check("fault_hold_outputs", outputs, 8'h00);
    check("fault_hold_flag", wdtFault, 1'b1);

    cycle(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1);
    $display("recover: outputs=%h wdtFault=%b upd=%b", outputs, wdtFault, outputsUpdated);
    check("recover_outputs", outputs, 8'hFE);
    check("recover_fault", wdtFault, 1'b0);
    check("recover_updated", outputsUpdated, 1'b1);

    // scanEnd landing exactly on the expiry cycle must prevent the trip.
    for (int k = 1; k <= 9; k++) idle();
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1);
    $display("expiry scan: outputs=%h wdtFault=%b upd=%b", outputs, wdtFault, outputsUpdated);
    check("expiry_scan_fault", wdtFault, 1'b0);
    check("expiry_scan_outputs", outputs, 8'hFE);
    check("expiry_scan_updated", outputsUpdated, 1'b1);
    idle();
    check("expiry_after_fault", wdtFault, 1'b0);
    check("expiry_after_updated", outputsUpdated, 1'b0);

    // Asynchronous reset between edges with pins at FF and count at 5.
    cycle(1'b1, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1);
    check("pre_reset_outputs", outputs, 8'hFF);
    for (int k = 0; k < 5; k++) idle();
    #3;
    reset = 1'b0;
    #1;
    $display("async reset: outputs=%h wdtFault=%b readOut=%b", outputs, wdtFault, outputReadOut);
    check("async_outputs", outputs, 8'h00);
    check("async_fault", wdtFault, 1'b0);
    check("async_readout", outputReadOut, 1'b0);
    #2;
    reset = 1'b1;

    cycle(1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b0);
    $display("post reset read a0: readOut=%b", outputReadOut);
    check("post_reset_read0", outputReadOut, 1'b0);
    // Restarted counter: fault appears on the 10th edge after release.
    for (int k = 2; k <= 10; k++) begin
      idle();
      if (k == 9) check("post_reset_pre_fault", wdtFault, 1'b0);
      if (k == 10) check("post_reset_fault", wdtFault, 1'b1);
    end
    $display("post reset watchdog: wdtFault=%b outputs=%h", wdtFault, outputs);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
